// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss stopwatch/countdown core.
//   timer_state_e : controller state (IDLE, RUN, PAUSED, DONE)
//   SEC_MAX/SEC_W : seconds field limit and width
//   MODE_UP/DOWN  : encoding of the mode input and the latched mode
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } timer_state_e;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned SEC_W   = 6;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts enabled clock cycles and flags the terminal count.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the count this cycle (otherwise hold)
//   clr        : synchronous return to zero, wins over en
//   tick       : high in the cycle whose edge wraps the count back to zero
module sec_prescaler #(
  parameter int unsigned CLK_PER_SEC = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational on purpose: the top registers the resulting time update and pulse.
  assign tick = en && !clr && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmss_timer.sv
// Minutes:seconds stopwatch / countdown core with internal one-second prescaler.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : sync clear to 00:00 / IDLE (highest priority)
//   start, stop, mode   : run control; stop beats start; mode latched on leaving a rest state
//   load, load_min/sec  : preset (clamped), ignored while running
//   minutes, seconds    : current time
//   running             : state is RUN
//   sec_tick/wrap/done  : one-cycle event pulses, all registered
// Optional build macro MMSS_TIMER_LAP_CAPTURE_EN adds lap, lap_min, lap_sec, lap_valid.
module mmss_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 100000000,
  parameter int unsigned MAX_MINUTES = 99,
  parameter int unsigned MIN_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [SEC_W-1:0] load_sec,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             running,
  output logic             sec_tick,
  output logic             wrap,
`ifdef MMSS_TIMER_LAP_CAPTURE_EN
  input  logic             lap,
  output logic [MIN_W-1:0] lap_min,
  output logic [SEC_W-1:0] lap_sec,
  output logic             lap_valid,
`endif
  output logic             done
);

  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MAX_MINUTES);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);

  timer_state_e     state_q, state_d;
  logic             mode_q, mode_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             running_q, running_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic psc_en, psc_clr, psc_tick;
  logic is_zero;

  assign is_zero = (min_q == '0) && (sec_q == '0);

  sec_prescaler #(
    .CLK_PER_SEC(CLK_PER_SEC)
  ) u_sec_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (psc_en),
    .clr  (psc_clr),
    .tick (psc_tick)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    min_d   = min_q;
    sec_d   = sec_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    psc_en  = 1'b0;
    psc_clr = 1'b0;

    if (clear) begin
      state_d = IDLE;
      min_d   = '0;
      sec_d   = '0;
      psc_clr = 1'b1;
    end else if (load && (state_q != RUN)) begin
      min_d   = (load_min > MIN_LAST) ? MIN_LAST : load_min;
      sec_d   = (load_sec > SEC_LAST) ? SEC_LAST : load_sec;
      psc_clr = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (stop) begin
            // Prescaler is held too, so a later resume keeps the partial second.
            state_d = PAUSED;
          end else begin
            psc_en = 1'b1;
            if (psc_tick) begin
              tick_d = 1'b1;
              if (mode_q == MODE_UP) begin
                if (sec_q == SEC_LAST) begin
                  sec_d = '0;
                  if (min_q == MIN_LAST) begin
                    min_d  = '0;
                    wrap_d = 1'b1;
                  end else begin
                    min_d = min_q + 1'b1;
                  end
                end else begin
                  sec_d = sec_q + 1'b1;
                end
              end else begin
                if (sec_q == '0) begin
                  sec_d = SEC_LAST;
                  min_d = min_q - 1'b1;
                end else begin
                  sec_d = sec_q - 1'b1;
                end
                // Only 00:01 reaches zero; X:00 with X>0 borrows to X-1:59.
                if ((min_q == '0) && (sec_q == SEC_W'(1))) begin
                  done_d  = 1'b1;
                  state_d = DONE;
                end
              end
            end
          end
        end
        IDLE, PAUSED: begin
          // Counting down from 00:00 would underflow, so such a start is refused.
          if (start && !stop && !((mode == MODE_DOWN) && is_zero)) begin
            state_d = RUN;
            mode_d  = mode;
            psc_clr = (state_q == IDLE);
          end
        end
        DONE: begin
          if (start && !stop && !is_zero) begin
            state_d = RUN;
            mode_d  = mode;
            psc_clr = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE_UP;
      min_q     <= '0;
      sec_q     <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
    end
  end

  assign minutes  = min_q;
  assign seconds  = sec_q;
  assign running  = running_q;
  assign sec_tick = tick_q;
  assign wrap     = wrap_q;
  assign done     = done_q;

`ifdef MMSS_TIMER_LAP_CAPTURE_EN
  logic [MIN_W-1:0] lap_min_q, lap_min_d;
  logic [SEC_W-1:0] lap_sec_q, lap_sec_d;
  logic             lap_valid_q, lap_valid_d;

  // Captures the post-update time so a lap on a tick edge records the new second.
  always_comb begin
    lap_min_d   = lap_min_q;
    lap_sec_d   = lap_sec_q;
    lap_valid_d = lap_valid_q;
    if (clear) begin
      lap_min_d   = '0;
      lap_sec_d   = '0;
      lap_valid_d = 1'b0;
    end else if (lap && ((state_q == RUN) || (state_q == PAUSED))) begin
      lap_min_d   = min_d;
      lap_sec_d   = sec_d;
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_min_q   <= '0;
      lap_sec_q   <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_min_q   <= lap_min_d;
      lap_sec_q   <= lap_sec_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_min   = lap_min_q;
  assign lap_sec   = lap_sec_q;
  assign lap_valid = lap_valid_q;
`endif

endmodule

// File: tb/tb_mmss_timer.sv
// Self-checking bench for mmss_timer: directed scenarios then random commands,
// every cycle compared against a total-seconds reference model.
module tb_mmss_timer;

  localparam int unsigned CPS   = 4;
  localparam int unsigned MAXM  = 2;
  localparam int unsigned MIN_W = 8;
  localparam int TOTAL = (MAXM + 1) * 60;

  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_PAUSED = 2;
  localparam int S_DONE   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear, start, stop, mode, load;
  logic [MIN_W-1:0] load_min;
  logic [5:0]       load_sec;
  logic [MIN_W-1:0] minutes;
  logic [5:0]       seconds;
  logic             running, sec_tick, wrap, done;
`ifdef MMSS_TIMER_LAP_CAPTURE_EN
  logic             lap = 1'b0;
  logic [MIN_W-1:0] lap_min;
  logic [5:0]       lap_sec;
  logic             lap_valid;
`endif

  mmss_timer #(
    .CLK_PER_SEC(CPS),
    .MAX_MINUTES(MAXM),
    .MIN_W      (MIN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .minutes  (minutes),
    .seconds  (seconds),
    .running  (running),
    .sec_tick (sec_tick),
    .wrap     (wrap),
`ifdef MMSS_TIMER_LAP_CAPTURE_EN
    .lap      (lap),
    .lap_min  (lap_min),
    .lap_sec  (lap_sec),
    .lap_valid(lap_valid),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: time kept as total seconds since 00:00.
  int m_t, m_psc, m_st, m_mode, m_tick, m_wrap, m_done;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_psc = 0; m_st = S_IDLE; m_mode = 0;
    m_tick = 0; m_wrap = 0; m_done = 0;
  endtask

  task automatic model_step(input bit c_clr, c_ld, c_stp, c_sta, c_md, input int lm, ls);
    bit ok;
    m_tick = 0; m_wrap = 0; m_done = 0;
    if (c_clr) begin
      m_t = 0; m_psc = 0; m_st = S_IDLE;
    end else if (c_ld && m_st != S_RUN) begin
      m_t   = ((lm > MAXM) ? MAXM : lm) * 60 + ((ls > 59) ? 59 : ls);
      m_psc = 0;
    end else if (m_st == S_RUN) begin
      if (c_stp) begin
        m_st = S_PAUSED;
      end else if (m_psc == CPS - 1) begin
        m_psc  = 0;
        m_tick = 1;
        if (m_mode == 0) begin
          m_t    = (m_t + 1) % TOTAL;
          m_wrap = (m_t == 0);
        end else begin
          m_t = m_t - 1;
          if (m_t == 0) begin
            m_done = 1;
            m_st   = S_DONE;
          end
        end
      end else begin
        m_psc++;
      end
    end else if (c_sta && !c_stp) begin
      if (m_st == S_DONE) ok = (m_t != 0);
      else                ok = !(c_md && m_t == 0);
      if (ok) begin
        if (m_st != S_PAUSED) m_psc = 0;
        m_st   = S_RUN;
        m_mode = c_md;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ":min"},  int'(minutes),  m_t / 60);
    check_eq({tag, ":sec"},  int'(seconds),  m_t % 60);
    check_eq({tag, ":run"},  int'(running),  int'(m_st == S_RUN));
    check_eq({tag, ":tick"}, int'(sec_tick), m_tick);
    check_eq({tag, ":wrap"}, int'(wrap),     m_wrap);
    check_eq({tag, ":done"}, int'(done),     m_done);
  endtask

  // One clock: drive commands, advance DUT and model together, compare after the edge.
  task automatic step(input string tag, input bit c_clr, c_ld, c_stp, c_sta, c_md,
                      input int lm, ls);
    clear = c_clr; load = c_ld; stop = c_stp; start = c_sta; mode = c_md;
    load_min = MIN_W'(lm); load_sec = 6'(ls);
    @(posedge clk);
    model_step(c_clr, c_ld, c_stp, c_sta, c_md, lm, ls);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_n(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Drop rst_n between edges and expect every output low before the next edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #2 rst_n = 1'b1;
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0; clear = 0; start = 0; stop = 0; mode = 0; load = 0;
    load_min = '0; load_sec = '0;
    model_reset();
    #12;
    compare_all("reset");
    rst_n = 1'b1;

    // 1: count up, tick every 4th cycle, 00:04 after 16 cycles.
    step("t1_start", 0, 0, 0, 1, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step("t1_run", 0, 0, 0, 0, 0, 0, 0);
      cnt += int'(sec_tick);
      check_eq("t1_tick_phase", int'(sec_tick), int'((i % 4) == 3));
    end
    check_eq("t1_ticks", cnt, 4);
    check_eq("t1_sec", int'(seconds), 4);

    // 2: wrap from 02:59 to 00:00 while still running.
    step("t2_clr", 1, 0, 0, 0, 0, 0, 0);
    step("t2_load", 0, 1, 0, 0, 0, 2, 58);
    step("t2_start", 0, 0, 0, 1, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step("t2_run", 0, 0, 0, 0, 0, 0, 0);
      cnt += int'(wrap);
      if (i == 3) check_eq("t2_at_259", int'(minutes) * 60 + int'(seconds), 179);
    end
    check_eq("t2_wraps", cnt, 1);
    check_eq("t2_zero", int'(minutes) * 60 + int'(seconds), 0);
    check_eq("t2_running", int'(running), 1);

    // 3: count down 00:02 to done; start at 00:00 in DONE ignored.
    step("t3_clr", 1, 0, 0, 0, 0, 0, 0);
    step("t3_load", 0, 1, 0, 0, 0, 0, 2);
    step("t3_start", 0, 0, 0, 1, 1, 0, 0);
    idle_n("t3_run", 4);
    check_eq("t3_at_001", int'(seconds), 1);
    idle_n("t3_run", 4);
    check_eq("t3_done", int'(done), 1);
    check_eq("t3_stopped", int'(running), 0);
    step("t3_restart_dn", 0, 0, 0, 1, 1, 0, 0);
    step("t3_restart_up", 0, 0, 0, 1, 0, 0, 0);
    check_eq("t3_stays_done", int'(running), 0);

    // 3b: down start at 00:00 from IDLE is refused.
    step("t3b_clr", 1, 0, 0, 0, 0, 0, 0);
    step("t3b_start", 0, 0, 0, 1, 1, 0, 0);
    check_eq("t3b_idle", int'(running), 0);

    // 4: pause keeps the partial second.
    step("t4_start", 0, 0, 0, 1, 0, 0, 0);
    idle_n("t4_run", 2);
    step("t4_stop", 0, 0, 1, 0, 0, 0, 0);
    idle_n("t4_paused", 10);
    check_eq("t4_held", int'(seconds), 0);
    step("t4_resume", 0, 0, 0, 1, 0, 0, 0);
    step("t4_r1", 0, 0, 0, 0, 0, 0, 0);
    check_eq("t4_no_tick_yet", int'(sec_tick), 0);
    step("t4_r2", 0, 0, 0, 0, 0, 0, 0);
    check_eq("t4_tick_after_2", int'(sec_tick), 1);

    // 5: clamped load in PAUSED, load ignored in RUN, start+stop stays PAUSED.
    step("t5_stop", 0, 0, 1, 0, 0, 0, 0);
    step("t5_load", 0, 1, 0, 0, 0, 200, 63);
    check_eq("t5_clamp", int'(minutes) * 60 + int'(seconds), 179);
    step("t5_start", 0, 0, 0, 1, 0, 0, 0);
    step("t5_load_run", 0, 1, 0, 0, 0, 0, 5);
    check_eq("t5_load_ignored", int'(minutes) * 60 + int'(seconds), 179);
    step("t5_stop2", 0, 0, 1, 0, 0, 0, 0);
    step("t5_both", 0, 0, 1, 1, 0, 0, 0);
    check_eq("t5_still_paused", int'(running), 0);

    // 6: async reset mid-run at 01:30, then clear beats load.
    step("t6_clr", 1, 0, 0, 0, 0, 0, 0);
    step("t6_load", 0, 1, 0, 0, 0, 1, 30);
    step("t6_start", 0, 0, 0, 1, 0, 0, 0);
    idle_n("t6_run", 2);
    async_reset("t6_rst");
    step("t6_clr_load", 1, 1, 0, 0, 0, 2, 10);
    check_eq("t6_zero", int'(minutes) * 60 + int'(seconds), 0);
    step("t6_idle_stop", 0, 0, 1, 0, 0, 0, 0);

    // Random command mix.
    for (int i = 0; i < 3000; i++) begin
      bit r_clr, r_ld, r_stp, r_sta, r_md;
      r_clr = ($urandom_range(99) < 2);
      r_ld  = ($urandom_range(99) < 6);
      r_stp = ($urandom_range(99) < 6);
      r_sta = ($urandom_range(99) < 15);
      r_md  = 1'($urandom_range(1));
      step("rnd", r_clr, r_ld, r_stp, r_sta, r_md,
           int'($urandom_range(255)), int'($urandom_range(63)));
      if ($urandom_range(999) == 0) async_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
